audio_tone_tx: RTL and testbench

Consumer end of the note path. Takes the 32-bit frequency word produced by the keyboard or the recorder's playback output (freqREC) and synthesizes a phase-continuous square wave. Serializes the resulting samples as an I2S stream (MCLK/SCK/LRCK/SDIN) to the board's stereo DAC. Frequency word 0 means silence.

---
 rtl/audio_tone_tx.sv | 109 ++++++++++
 tb/tb_audio_tone_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/audio_tone_tx.sv
// audio_tone_tx: phase-continuous square-wave tone synthesizer
// feeding an I2S stereo DAC (MCLK/SCK/LRCK/SDIN).
module audio_tone_tx #(
  parameter int CLK_HZ   = 100000000,
  parameter int SCK_HALF = 8,
  parameter int SAMPLE_W = 16,
  parameter int MAX_FREQ = 20000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         freq,
  input  logic [SAMPLE_W-2:0] amp,
  output logic                mclk,
  output logic                sck,
  output logic                lrck,
  output logic                sdin,
  output logic                tone_on,
  output logic [SAMPLE_W-1:0] sample,
  output logic                frame_strobe
);

  localparam logic [31:0] HALF = 32'(CLK_HZ / 2);
  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] SCK_LAST = CW'(SCK_HALF - 1);

  logic [31:0]         acc;
  logic [31:0]         sum;
  logic                square;
  logic                valid;
  logic                mdiv;
  logic [CW-1:0]       sdiv;
  logic [5:0]          b;
  logic [5:0]          b_next;
  logic                run;
  logic                fall;
  logic                fstart;
  logic [SAMPLE_W-1:0] amp_ext;
  logic [SAMPLE_W-1:0] tone_word;
  logic [SAMPLE_W-1:0] frame_word;
  logic [4:0]          k;
  logic                data_bit;

  // run marks that a frame is in progress; until then the first
  // fall forces b_next to 0 so every frame begins at slot 0.
  always_comb begin
    valid      = (freq != 32'd0) && (freq <= 32'(MAX_FREQ));
    sum        = acc + freq;
    fall       = sck && (sdiv == SCK_LAST);
    b_next     = run ? b + 6'd1 : 6'd0;
    fstart     = fall && (b_next == 6'd0);
    amp_ext    = {1'b0, amp};
    tone_word  = !tone_on ? '0 : (square ? amp_ext : -amp_ext);
    frame_word = fstart ? tone_word : sample;
    k          = b_next[4:0];
    data_bit   = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (int'(k) == SAMPLE_W - i) data_bit = frame_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      square       <= 1'b0;
      tone_on      <= 1'b0;
      mdiv         <= 1'b0;
      mclk         <= 1'b0;
      sdiv         <= '0;
      sck          <= 1'b0;
      b            <= '0;
      run          <= 1'b0;
      lrck         <= 1'b0;
      sdin         <= 1'b0;
      sample       <= '0;
      frame_strobe <= 1'b0;
    end else begin
      tone_on <= valid;
      if (!valid) begin
        acc    <= '0;
        square <= 1'b0;
      end else if (sum >= HALF) begin
        acc    <= sum - HALF;
        square <= ~square;
      end else begin
        acc <= sum;
      end

      mdiv <= ~mdiv;
      if (mdiv) mclk <= ~mclk;

      if (sdiv == SCK_LAST) begin
        sdiv <= '0;
        sck  <= ~sck;
      end else begin
        sdiv <= sdiv + 1'b1;
      end

      frame_strobe <= fstart;
      if (fall) begin
        run  <= 1'b1;
        b    <= b_next;
        lrck <= b_next[5];
        sdin <= data_bit;
        if (fstart) sample <= tone_word;
      end
    end
  end

endmodule

// File: tb/tb_audio_tone_tx.sv
// tb_audio_tone_tx: random tone stimulus, phase-sum reference model,
// scoreboard of per-frame samples and I2S word decoding.
module tb_audio_tone_tx;
  localparam int CLK_HZ = 2000000;
  localparam int SH     = 8;
  localparam int SW     = 16;
  localparam int MAXF   = 20000;
  localparam longint HALF = CLK_HZ / 2;
  localparam int FRAME  = 128 * SH;

  logic          clk = 0;
  logic          reset = 1;
  logic [31:0]   freq = 0;
  logic [SW-2:0] amp = 0;
  logic          mclk, sck, lrck, sdin, tone_on, frame_strobe;
  logic [SW-1:0] sample;

  audio_tone_tx #(
    .CLK_HZ(CLK_HZ), .SCK_HALF(SH), .SAMPLE_W(SW), .MAX_FREQ(MAXF)
  ) dut (
    .clk(clk), .reset(reset), .freq(freq), .amp(amp),
    .mclk(mclk), .sck(sck), .lrck(lrck), .sdin(sdin),
    .tone_on(tone_on), .sample(sample), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [SW-1:0] exp_word(bit t, bit sq, logic [SW-2:0] a);
    int v;
    if (!t) return '0;
    v = sq ? int'(a) : -int'(a);
    return v[SW-1:0];
  endfunction

  // Reference model: square is the parity of how many HALF boundaries
  // the running phase sum has crossed since the tone became valid.
  typedef struct { int n; logic [SW-1:0] s; } fr_t;
  fr_t    q[$];
  longint phase = 0;
  bit     m_tone = 0, m_sq = 0, was_rst = 0;
  int     n = 0;

  always @(posedge clk) begin
    was_rst = reset;
    if (reset) begin
      phase = 0; m_tone = 0; m_sq = 0; n = 0;
      q.delete();
    end else begin
      n++;
      if (n % FRAME == 2 * SH) q.push_back('{n, exp_word(m_tone, m_sq, amp)});
      if (freq == 0 || freq > MAXF) begin
        phase = 0; m_tone = 0;
      end else begin
        phase += freq; m_tone = 1;
      end
      m_sq = ((phase / HALF) % 2) == 1;
    end
  end

  // Monitor: sampled on the falling clk edge.
  bit [63:0]     bits;
  int            r = 0;
  bit            dec = 0, sck_prev = 0, first_pend = 1;
  logic [SW-1:0] cur, lw, rw;
  fr_t           it;

  always @(negedge clk) begin
    if (was_rst) begin
      check("reset_outs", {mclk, sck, lrck, sdin, tone_on, frame_strobe, sample}, 0);
      dec = 0; r = 0; sck_prev = 0; first_pend = 1;
    end else begin
      check("tone_on", tone_on, m_tone);
      check("mclk", mclk, (n / 2) % 2);
      check("sck", sck, (n / SH) % 2);
      if (frame_strobe) begin
        if (q.size() == 0) begin
          check("strobe_unexpected", 1, 0);
        end else begin
          it = q.pop_front();
          check("strobe_time", n, it.n);
          check("sample", sample, it.s);
          cur = it.s; dec = 1; r = 0;
        end
      end
      if (sck && !sck_prev) begin
        if (first_pend) begin
          check("first_rise", n, SH);
          first_pend = 0;
        end
        if (dec) begin
          bits[r] = sdin;
          check("lrck_slot", lrck, r >= 32);
          r++;
          if (r == 64) begin
            for (int i = 0; i < SW; i++) begin
              lw[SW-1-i] = bits[1+i];
              rw[SW-1-i] = bits[33+i];
              bits[1+i] = 0;
              bits[33+i] = 0;
            end
            check("left_word", lw, cur);
            check("right_word", rw, cur);
            check("padding", bits, 0);
            check("sample_held", sample, cur);
            dec = 0;
          end
        end
      end
      sck_prev = sck;
    end
  end

  task automatic run_cycles(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    run_cycles(3);
    reset = 0;
    freq = 0; amp = 15'h1234;
    run_cycles(4 * FRAME);
    freq = 440; amp = 15'h1000;
    run_cycles(6 * FRAME);
    freq = 25000;
    run_cycles(2 * FRAME);
    freq = 20000;
    run_cycles(2 * FRAME + 37);
    freq = 440; amp = 15'h2abc;
    run_cycles(3 * FRAME + 100);
    freq = 880;
    run_cycles(3 * FRAME);
    freq = 1000; amp = 15'h7fff;
    for (int i = 0; i < 2 * FRAME && (n % FRAME) != 2 * SH; i++) run_cycles(1);
    run_cycles(2 * SH * 36);
    reset = 1;
    run_cycles(3);
    reset = 0;
    run_cycles(2 * FRAME);
    for (int s = 0; s < 15; s++) begin
      case ($urandom_range(0, 4))
        0: freq = 0;
        1: freq = MAXF + $urandom_range(1, 100000);
        2: freq = $urandom_range(1, MAXF);
        default: freq = $urandom_range(50, 2000);
      endcase
      amp = 15'($urandom);
      run_cycles($urandom_range(200, 3000));
    end
    run_cycles(FRAME + 40);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
